// File: rtl/mux8_rr_arbiter_if.sv
// Bundle of the arbiter-facing signals: requester side (req/data_in)
// and the grant / shared-mux side (grant, sel, status pulses, y_out).
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] data_in;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       y_out;
    logic       rel_pulse;
    logic       timeout;

    // The requesting side drives req/data_in and observes everything else
    modport master (
        output req, data_in,
        input  grant, sel, busy, y_out, rel_pulse, timeout
    );

    // The arbiter consumes req/data_in and produces grant, select and status
    modport slave (
        input  req, data_in,
        output grant, sel, busy, y_out, rel_pulse, timeout
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter in front of a shared 8:1 one-bit mux.
// States IDLE -> GRANT -> GAP -> IDLE; GAP is a one-cycle turnaround.
// Optional macro ARB_TIMEOUT_EN: force-release an owner after MAX_HOLD
// consecutive grant cycles and pulse timeout during that GAP cycle.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input logic             clk,
    input logic             rst_n,
    mux8_rr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] last_q, last_d;
    logic       found;
    logic [2:0] winner;

    // Reject parameter combinations the hold counter cannot represent
    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (2 ** CNT_W) <= MAX_HOLD) begin : g_param_check
        $error("mux8_rr_arbiter: MAX_HOLD must be 1..15 and fit in CNT_W bits");
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT   = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Round-robin search: first set request strictly after the last owner
    always_comb begin
        logic [2:0] idx;
        found  = 1'b0;
        winner = 3'd0;
        idx    = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = last_q + 3'(k);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Next-state and next-register values for the IDLE/GRANT/GAP sequence
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = 8'(1) << winner;
                    sel_d   = winner;
                    last_d  = winner;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    state_d = GAP;
                    grant_d = 8'h00;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == HOLD_LIMIT) begin
                    state_d   = GAP;
                    grant_d   = 8'h00;
                    timeout_d = 1'b1;
                end
                else if (cnt_q != HOLD_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'h00;
            end
        endcase
    end

    // State and arbitration registers; reset points the search at index 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 8'h00;
            sel_q   <= 3'd0;
            last_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and the registered force-release pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == GRANT);
    assign bus.rel_pulse = (state_q == GAP);
    assign bus.y_out     = (state_q == GRANT) ? bus.data_in[sel_q] : 1'b0;

endmodule
